mips_pipe_muldiv: RTL

Parametrised iterative multiply/divide pipe for the MIPS I core, owning the HI/LO register pair.
- Decodes MULT/MULTU/DIV/DIVU, MFHI/MFLO and MTHI/MTLO from the ID opcode.
- Runs a multi-cycle shift-add or restoring-divide engine.
- Drives the OR-combined EX result/target bus like the other pipes.
- Adds an interlock (stall) that the single-cycle pipes do not need.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mips_muldiv_step.sv | 41 ++++
 rtl/mips_pipe_muldiv.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide engine state encoding.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

    // MULT and DIV have bit 0 clear; MULTU and DIVU set it.
    function automatic logic fn_is_signed(input logic [5:0] fn);
        return ~fn[0];
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One engine iteration: STEP shift-add multiply steps or STEP restoring divide steps.
// Divide keeps {remainder, quotient/dividend} in acc; quotient bits enter at the bottom.
module mips_muldiv_step
    import mips_pkg::*;
#(
    parameter int W    = 32,
    parameter int STEP = 1
) (
    input  logic           div,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   opnd,
    output logic [2*W-1:0] acc_next
);

    logic [2*W-1:0] a_v;
    logic [W:0]     sum_v;
    logic [W:0]     shl_v;
    logic [W:0]     diff_v;
    logic           ge_v;

    always_comb begin
        a_v    = acc;
        sum_v  = '0;
        shl_v  = '0;
        diff_v = '0;
        ge_v   = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            // Multiply: low half holds the unconsumed multiplier, product shifts in from the top.
            sum_v  = {1'b0, a_v[2*W-1:W]} + (a_v[0] ? {1'b0, opnd} : '0);
            shl_v  = {a_v[2*W-1:W], a_v[W-1]};
            ge_v   = shl_v >= {1'b0, opnd};
            diff_v = shl_v - {1'b0, opnd};
            if (div)
                a_v = {(ge_v ? diff_v[W-1:0] : shl_v[W-1:0]), a_v[W-2:0], ge_v};
            else
                a_v = {sum_v, a_v[W-1:1]};
        end
        acc_next = a_v;
    end

endmodule

// File: rtl/mips_pipe_muldiv.sv
// Iterative multiply/divide pipe owning HI/LO, with an interlock for HI/LO moves while busy.
// Optional early-out multiply when MIPS_MULDIV_EARLY_EN is defined.
module mips_pipe_muldiv
    import mips_pkg::*;
#(
    parameter int W    = 32,
    parameter int STEP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  op,
    input  logic [31:0]  next,
    input  logic [W-1:0] S,
    input  logic [W-1:0] T,
    output logic [W-1:0] result,
    output logic [4:0]   target,
    output logic         busy,
    output logic         stall
);

    localparam int N  = W / STEP;
    localparam int CW = $clog2(N + 1);

    md_state_t      state_reg;
    logic [W-1:0]   hi_reg, lo_reg, opnd_reg, result_reg;
    logic [4:0]     target_reg;
    logic [2*W-1:0] acc_reg, acc_next, fix_val;
    logic [CW-1:0]  count_reg;
    logic           div_reg, neg_lo_reg, neg_hi_reg;
`ifdef MIPS_MULDIV_EARLY_EN
    logic [W-1:0]   mplier_reg;
`endif

    logic [5:0]   fn;
    logic         special, is_mf, is_mt, is_start, is_div, is_signed;
    logic         s_neg, t_neg, take_mf, take_mt;
    logic [W-1:0] s_mag, t_mag;
    logic         unused_ok;

    assign fn        = op[5:0];
    assign special   = (op[31:26] == OP_SPECIAL);
    assign is_mf     = special & ((fn == FN_MFHI) | (fn == FN_MFLO));
    assign is_mt     = special & ((fn == FN_MTHI) | (fn == FN_MTLO));
    assign is_start  = special & ((fn == FN_MULT) | (fn == FN_MULTU) | (fn == FN_DIV) | (fn == FN_DIVU));
    assign is_div    = fn[1];
    assign is_signed = fn_is_signed(fn);
    assign s_neg     = is_signed & S[W-1];
    assign t_neg     = is_signed & T[W-1];
    assign s_mag     = s_neg ? -S : S;
    assign t_mag     = t_neg ? -T : T;

    assign busy    = (state_reg != IDLE);
    assign stall   = busy & (is_mf | is_mt);
    assign take_mf = is_mf & ~busy;
    assign take_mt = is_mt & ~busy;

    assign unused_ok = ^{next, op[25:16], op[10:6]};

    mips_muldiv_step #(.W(W), .STEP(STEP)) u_step (
        .div      (div_reg),
        .acc      (acc_reg),
        .opnd     (opnd_reg),
        .acc_next (acc_next)
    );

    // Products negate as a whole; quotient and remainder carry independent signs.
    always_comb begin
        if (div_reg)
            fix_val = {(neg_hi_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W]),
                       (neg_lo_reg ? -acc_reg[W-1:0]   : acc_reg[W-1:0])};
        else
            fix_val = neg_lo_reg ? -acc_reg : acc_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
            target_reg <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            count_reg  <= '0;
            div_reg    <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
`ifdef MIPS_MULDIV_EARLY_EN
            mplier_reg <= '0;
`endif
        end else begin
            result_reg <= '0;
            target_reg <= '0;
            if (take_mf) begin
                result_reg <= (fn == FN_MFHI) ? hi_reg : lo_reg;
                target_reg <= op[15:11];
            end
            if (take_mt) begin
                if (fn == FN_MTHI) hi_reg <= S;
                else               lo_reg <= S;
            end
            if (state_reg == FIX)
                {hi_reg, lo_reg} <= fix_val;

            // A new start always wins over the running operation, including in FIX.
            if (is_start) begin
                div_reg    <= is_div;
                acc_reg    <= {{W{1'b0}}, (is_div ? s_mag : t_mag)};
                opnd_reg   <= is_div ? t_mag : s_mag;
                neg_lo_reg <= is_div ? ((s_neg ^ t_neg) & (T != '0)) : (s_neg ^ t_neg);
                neg_hi_reg <= s_neg;
                count_reg  <= CW'(N - 1);
                state_reg  <= is_div ? DIV : MUL;
`ifdef MIPS_MULDIV_EARLY_EN
                mplier_reg <= t_mag;
`endif
            end else begin
                case (state_reg)
                    MUL: begin
`ifdef MIPS_MULDIV_EARLY_EN
                        if (mplier_reg == '0) begin
                            acc_reg   <= acc_reg >> ((int'(count_reg) + 1) * STEP);
                            state_reg <= FIX;
                        end else begin
                            acc_reg    <= acc_next;
                            mplier_reg <= mplier_reg >> STEP;
                            if (count_reg == '0) state_reg <= FIX;
                            else                 count_reg <= count_reg - 1'b1;
                        end
`else
                        acc_reg <= acc_next;
                        if (count_reg == '0) state_reg <= FIX;
                        else                 count_reg <= count_reg - 1'b1;
`endif
                    end
                    DIV: begin
                        acc_reg <= acc_next;
                        if (count_reg == '0) state_reg <= FIX;
                        else                 count_reg <= count_reg - 1'b1;
                    end
                    FIX:     state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign result = result_reg;
    assign target = target_reg;

endmodule
